// File: rtl/round_key_store_if.sv
// round_key_store_if
// Bundles the control, write and read signals of the round-key store.
//   master : key-expansion unit / round pipeline side (drives requests)
//   slave  : round_key_store side (drives responses and status)
// Signals:
//   start, cfg_nkeys  - begin a key-load session with cfg_nkeys keys
//   zeroize           - wipe request
//   wr_en/idx/key     - key write port
//   rd_req/idx        - read request
//   rd_ack/hit/key    - registered read response
//   wr_err            - one-cycle pulse for a rejected write
//   ready, busy       - load complete / wipe in progress
interface round_key_store_if #(
    parameter int KEY_W = 128,
    parameter int IDX_W = 4
);
    logic             start;
    logic [IDX_W:0]   cfg_nkeys;
    logic             zeroize;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [KEY_W-1:0] wr_key;
    logic             rd_req;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_ack;
    logic             rd_hit;
    logic [KEY_W-1:0] rd_key;
    logic             wr_err;
    logic             ready;
    logic             busy;

    modport master (
        output start, cfg_nkeys, zeroize, wr_en, wr_idx, wr_key, rd_req, rd_idx,
        input  rd_ack, rd_hit, rd_key, wr_err, ready, busy
    );

    modport slave (
        input  start, cfg_nkeys, zeroize, wr_en, wr_idx, wr_key, rd_req, rd_idx,
        output rd_ack, rd_hit, rd_key, wr_err, ready, busy
    );
endinterface

// File: rtl/round_key_store.sv
// round_key_store
// Storage for up to DEPTH AES round keys with per-slot valid bits, a load
// state machine that reports ready once all configured keys are present,
// registered reads that report a miss for unloaded slots, and a
// multi-cycle zeroize sequence that clears every slot.
// Ports:
//   clk   - clock
//   n_rst - asynchronous active-low reset
//   bus   - round_key_store_if.slave (control, write port, read port, status)
module round_key_store #(
    parameter int KEY_W = 128,
    parameter int DEPTH = 15,
    parameter int IDX_W = 4
) (
    input logic              clk,
    input logic              n_rst,
    round_key_store_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, READY, WIPE} state_t;

    localparam logic [IDX_W:0]   DEPTH_N  = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t           state;
    logic [KEY_W-1:0] slots [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [IDX_W:0]   nkeys;
    logic [IDX_W-1:0] wipe_cnt;

    logic             rd_ack_q;
    logic             rd_hit_q;
    logic [KEY_W-1:0] rd_key_q;
    logic             wr_err_q;

    logic             start_go;
    logic             wr_ok;
    logic             wr_bad;
    logic             rd_ok;
    logic [IDX_W:0]   nkeys_clamped;
    logic [DEPTH-1:0] mask;
    logic [DEPTH-1:0] wr_onehot;
    logic [DEPTH-1:0] valid_next;

    always_comb begin
        // zeroize wins over start; start is meaningless while wiping
        start_go = bus.start && !bus.zeroize && (state != WIPE);

        // a write coinciding with an effective start is dropped silently
        wr_ok  = bus.wr_en && !bus.zeroize && !start_go &&
                 ((state == LOAD) || (state == READY)) &&
                 ({1'b0, bus.wr_idx} < nkeys);
        wr_bad = bus.wr_en && !bus.zeroize && !start_go && !wr_ok;

        rd_ok = ({1'b0, bus.rd_idx} < nkeys) && (state != WIPE);
        if (rd_ok) begin
            rd_ok = valid[bus.rd_idx];
        end

        if (bus.cfg_nkeys == '0) begin
            nkeys_clamped = (IDX_W+1)'(1);
        end else if (bus.cfg_nkeys > DEPTH_N) begin
            nkeys_clamped = DEPTH_N;
        end else begin
            nkeys_clamped = bus.cfg_nkeys;
        end

        mask      = '0;
        wr_onehot = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mask[i] = ((IDX_W+1)'(i) < nkeys);
        end
        if (wr_ok) begin
            wr_onehot[bus.wr_idx] = 1'b1;
        end
        // includes this edge's write so ready rises right after the last key
        valid_next = valid | wr_onehot;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            valid    <= '0;
            nkeys    <= '0;
            wipe_cnt <= '0;
            rd_ack_q <= 1'b0;
            rd_hit_q <= 1'b0;
            rd_key_q <= '0;
            wr_err_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            // read samples pre-write contents, giving old data on a collision
            rd_ack_q <= bus.rd_req;
            rd_hit_q <= bus.rd_req && rd_ok;
            rd_key_q <= (bus.rd_req && rd_ok) ? slots[bus.rd_idx] : '0;
            wr_err_q <= wr_bad;

            if (wr_ok) begin
                slots[bus.wr_idx] <= bus.wr_key;
            end

            if (bus.zeroize) begin
                state    <= WIPE;
                valid    <= '0;
                wipe_cnt <= '0;
            end else if (start_go) begin
                nkeys <= nkeys_clamped;
                valid <= '0;
                state <= LOAD;
            end else begin
                case (state)
                    LOAD: begin
                        valid <= valid_next;
                        if ((valid_next & mask) == mask) begin
                            state <= READY;
                        end
                    end
                    READY: begin
                        valid <= valid_next;
                    end
                    WIPE: begin
                        slots[wipe_cnt] <= '0;
                        wipe_cnt        <= wipe_cnt + 1'b1;
                        if (wipe_cnt == LAST_IDX) begin
                            state <= IDLE;
                            nkeys <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rd_ack = rd_ack_q;
    assign bus.rd_hit = rd_hit_q;
    assign bus.rd_key = rd_key_q;
    assign bus.wr_err = wr_err_q;
    assign bus.ready  = (state == READY);
    assign bus.busy   = (state == WIPE);
endmodule

// File: tb/tb_round_key_store.sv
// tb_round_key_store
// Directed bench for round_key_store (KEY_W=128, DEPTH=15, IDX_W=4).
// Inputs change 1 ns after the rising edge; outputs are checked there too,
// so each check observes the result of the edge just taken.
module tb_round_key_store;
    localparam int KEY_W = 128;
    localparam int DEPTH = 15;
    localparam int IDX_W = 4;

    logic clk;
    logic n_rst;
    int   tests;
    int   fails;

    round_key_store_if #(.KEY_W(KEY_W), .IDX_W(IDX_W)) bus ();

    round_key_store #(.KEY_W(KEY_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] kv(input int i);
        return 128'h0123456789ABCDEF_FEDCBA9876543200 + 128'(i);
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start     = 1'b0;
        bus.cfg_nkeys = '0;
        bus.zeroize   = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_idx    = '0;
        bus.wr_key    = '0;
        bus.rd_req    = 1'b0;
        bus.rd_idx    = '0;
    endtask

    task automatic wr(input int idx, input logic [127:0] k, input logic exp_err);
        bus.wr_en  = 1'b1;
        bus.wr_idx = 4'(idx);
        bus.wr_key = k;
        tick();
        bus.wr_en = 1'b0;
        check("wr_err", bus.wr_err, exp_err);
    endtask

    task automatic rd(input int idx, input logic exp_hit, input logic [127:0] exp_key);
        bus.rd_req = 1'b1;
        bus.rd_idx = 4'(idx);
        tick();
        bus.rd_req = 1'b0;
        check("rd_ack", bus.rd_ack, 1'b1);
        check("rd_hit", bus.rd_hit, exp_hit);
        check("rd_key", bus.rd_key, exp_key);
    endtask

    task automatic do_start(input int n);
        bus.start     = 1'b1;
        bus.cfg_nkeys = 5'(n);
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clear_inputs();
        n_rst = 1'b0;
        #12;
        check("rst_ready", bus.ready, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_rd_ack", bus.rd_ack, 1'b0);
        check("rst_wr_err", bus.wr_err, 1'b0);
        check("rst_rd_key", bus.rd_key, '0);
        @(negedge clk);
        n_rst = 1'b1;

        // IDLE: reads miss, writes are rejected with a single-cycle pulse
        rd(0, 1'b0, '0);
        wr(0, kv(0), 1'b1);
        tick();
        check("wr_err_pulse", bus.wr_err, 1'b0);

        // AES-128 in-order load
        do_start(11);
        check("load_ready0", bus.ready, 1'b0);
        for (int i = 0; i < 11; i++) begin
            wr(i, kv(i), 1'b0);
            check("load_ready", bus.ready, (i == 10));
        end
        for (int i = 0; i < 11; i++) begin
            rd(i, 1'b1, kv(i));
        end
        rd(11, 1'b0, '0);
        wr(11, kv(99), 1'b1);
        check("ready_after_err", bus.ready, 1'b1);

        // same-cycle read and write of slot 3 returns the old key
        bus.wr_en  = 1'b1;
        bus.wr_idx = 4'd3;
        bus.wr_key = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;
        bus.rd_req = 1'b1;
        bus.rd_idx = 4'd3;
        tick();
        clear_inputs();
        check("coll_hit", bus.rd_hit, 1'b1);
        check("coll_key", bus.rd_key, kv(3));
        check("coll_err", bus.wr_err, 1'b0);
        rd(3, 1'b1, 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB);

        // restart with 13 keys: old contents never hit
        do_start(13);
        check("restart_ready", bus.ready, 1'b0);
        rd(3, 1'b0, '0);
        for (int i = 0; i < 13; i++) begin
            wr(i, kv(100 + i), 1'b0);
            check("r13_ready", bus.ready, (i == 12));
        end
        rd(5, 1'b1, kv(105));
        rd(13, 1'b0, '0);

        // start together with a write: write dropped without error
        bus.start     = 1'b1;
        bus.cfg_nkeys = 5'd15;
        bus.wr_en     = 1'b1;
        bus.wr_idx    = 4'd0;
        bus.wr_key    = kv(77);
        tick();
        clear_inputs();
        check("start_wr_err", bus.wr_err, 1'b0);
        check("start_ready", bus.ready, 1'b0);
        rd(0, 1'b0, '0);

        // out-of-order load of all 15 slots
        for (int i = 14; i >= 0; i--) begin
            wr(i, kv(200 + i), 1'b0);
            check("ooo_ready", bus.ready, (i == 0));
        end
        rd(14, 1'b1, kv(214));
        rd(0, 1'b1, kv(200));
        wr(15, kv(1), 1'b1);
        check("ooo_ready_kept", bus.ready, 1'b1);
        rd(15, 1'b0, '0);

        // clamping: 31 -> 15, 0 -> 1
        do_start(31);
        wr(14, kv(314), 1'b0);
        wr(15, kv(315), 1'b1);
        do_start(0);
        wr(1, kv(1), 1'b1);
        check("clamp1_ready0", bus.ready, 1'b0);
        wr(0, kv(7), 1'b0);
        check("clamp1_ready", bus.ready, 1'b1);

        // zeroize from READY: DEPTH busy cycles, reads miss, writes error
        bus.zeroize = 1'b1;
        tick();
        bus.zeroize = 1'b0;
        check("zero_busy", bus.busy, 1'b1);
        check("zero_ready", bus.ready, 1'b0);
        for (int c = 1; c < DEPTH; c++) begin
            if (c == 2) begin
                bus.rd_req = 1'b1;
                bus.rd_idx = 4'd0;
            end
            if (c == 3) begin
                bus.wr_en  = 1'b1;
                bus.wr_idx = 4'd0;
                bus.wr_key = kv(5);
            end
            tick();
            clear_inputs();
            check("wipe_busy", bus.busy, 1'b1);
            if (c == 2) begin
                check("wipe_rd_ack", bus.rd_ack, 1'b1);
                check("wipe_rd_hit", bus.rd_hit, 1'b0);
                check("wipe_rd_key", bus.rd_key, '0);
            end
            if (c == 3) begin
                check("wipe_wr_err", bus.wr_err, 1'b1);
            end
        end
        tick();
        check("wipe_done_busy", bus.busy, 1'b0);
        check("wipe_done_ready", bus.ready, 1'b0);
        wr(0, kv(8), 1'b1);
        do_start(1);
        wr(0, kv(9), 1'b0);
        check("post_wipe_ready", bus.ready, 1'b1);
        rd(0, 1'b1, kv(9));
        rd(5, 1'b0, '0);

        // zeroize and start together -> WIPE, then async reset at wipe cycle 4
        bus.zeroize   = 1'b1;
        bus.start     = 1'b1;
        bus.cfg_nkeys = 5'd11;
        tick();
        clear_inputs();
        check("zs_busy", bus.busy, 1'b1);
        check("zs_ready", bus.ready, 1'b0);
        bus.rd_req = 1'b1;
        bus.wr_en  = 1'b1;
        bus.wr_idx = 4'd0;
        for (int c = 0; c < 3; c++) begin
            tick();
        end
        check("pre_rst_ack", bus.rd_ack, 1'b1);
        check("pre_rst_err", bus.wr_err, 1'b1);
        check("pre_rst_busy", bus.busy, 1'b1);
        n_rst = 1'b0;
        #1;
        check("async_busy", bus.busy, 1'b0);
        check("async_ready", bus.ready, 1'b0);
        check("async_rd_ack", bus.rd_ack, 1'b0);
        check("async_wr_err", bus.wr_err, 1'b0);
        clear_inputs();
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        check("rel_busy", bus.busy, 1'b0);
        check("rel_ack", bus.rd_ack, 1'b0);
        wr(0, kv(1), 1'b1);
        check("rel_ready", bus.ready, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
